// File: rtl/compare_result_monitor.sv
// compare_result_monitor: qualifies one-hot comparator flags, tracks the accepted relation,
// counts relation changes per destination, and raises a sticky change interrupt.
module compare_result_monitor #(
    parameter int FILT_LEN = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    input  logic             clear,
    input  logic             irq_ack,
    output logic [1:0]       rel_state,
    output logic             rel_valid,
    output logic             change_pulse,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             irq
);
    typedef enum logic [1:0] {UNKNOWN = 2'b00, LT = 2'b01, EQ = 2'b10, GT = 2'b11} rel_t;

    localparam logic [3:0]       FL   = 4'(FILT_LEN);
    localparam logic [CNT_W-1:0] CMAX = '1;

    rel_t       state, state_nxt, run_rel, sample_rel;
    logic [3:0] run_len, len_nxt;
    logic       legal, take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    // run_rel is UNKNOWN whenever no run is in progress, so it never matches a legal sample
    always_comb begin
        legal      = (a_gt_b ^ a_eq_b ^ a_lt_b) & ~(a_gt_b & a_eq_b & a_lt_b);
        sample_rel = a_gt_b ? GT : a_eq_b ? EQ : LT;
        len_nxt    = (sample_rel == run_rel) ? ((run_len >= FL) ? FL : run_len + 4'd1) : 4'd1;
        take       = in_valid && legal && len_nxt == FL && sample_rel != state;
        state_nxt  = clear ? UNKNOWN : take ? sample_rel : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= UNKNOWN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_rel      <= UNKNOWN;
            run_len      <= '0;
            change_pulse <= 1'b0;
            irq          <= 1'b0;
            gt_cnt       <= '0;
            eq_cnt       <= '0;
            lt_cnt       <= '0;
            err_cnt      <= '0;
        end else if (clear) begin
            run_rel      <= UNKNOWN;
            run_len      <= '0;
            change_pulse <= 1'b0;
            irq          <= 1'b0;
            gt_cnt       <= '0;
            eq_cnt       <= '0;
            lt_cnt       <= '0;
            err_cnt      <= '0;
        end else begin
            change_pulse <= take;
            irq          <= take | (irq & ~irq_ack);
            if (in_valid && legal) begin
                run_rel <= sample_rel;
                run_len <= len_nxt;
            end else if (in_valid) begin
                run_rel <= UNKNOWN;
                run_len <= '0;
                err_cnt <= sat_inc(err_cnt);
            end
            if (take && sample_rel == GT) gt_cnt <= sat_inc(gt_cnt);
            if (take && sample_rel == EQ) eq_cnt <= sat_inc(eq_cnt);
            if (take && sample_rel == LT) lt_cnt <= sat_inc(lt_cnt);
        end
    end

    assign rel_state = state;
    assign rel_valid = state != UNKNOWN;
endmodule

// File: tb/tb_compare_result_monitor.sv
// tb_compare_result_monitor: directed and random checks of two monitor configurations
// (FILT_LEN=3/CNT_W=8 and FILT_LEN=1/CNT_W=2) against a behavioural model.
module tb_compare_result_monitor;
    logic clk = 0, rst_n = 1, in_valid = 0, a_gt_b = 0, a_eq_b = 0, a_lt_b = 0, clear = 0, irq_ack = 0;
    logic [1:0] rs0, rs1;
    logic       rv0, rv1, cp0, cp1, irq0, irq1;
    logic [7:0] gc0, ec0, lc0, er0;
    logic [1:0] gc1, ec1, lc1, er1;

    always #5 clk = ~clk;

    compare_result_monitor #(.FILT_LEN(3), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
        .a_lt_b(a_lt_b), .clear(clear), .irq_ack(irq_ack), .rel_state(rs0), .rel_valid(rv0),
        .change_pulse(cp0), .gt_cnt(gc0), .eq_cnt(ec0), .lt_cnt(lc0), .err_cnt(er0), .irq(irq0));

    compare_result_monitor #(.FILT_LEN(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
        .a_lt_b(a_lt_b), .clear(clear), .irq_ack(irq_ack), .rel_state(rs1), .rel_valid(rv1),
        .change_pulse(cp1), .gt_cnt(gc1), .eq_cnt(ec1), .lt_cnt(lc1), .err_cnt(er1), .irq(irq1));

    int checks = 0, errors = 0, pulses1 = 0;
    int filt[2] = '{3, 1};
    int cmax[2] = '{255, 3};
    // relation codes: 0 none/unknown, 1 LT, 2 EQ, 3 GT
    int m_st[2], m_rrel[2], m_rlen[2], m_pulse[2], m_irq[2], m_err[2];
    int m_cnt[2][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_rrel[i] = 0; m_rlen[i] = 0; m_pulse[i] = 0; m_irq[i] = 0; m_err[i] = 0;
            for (int r = 0; r < 4; r++) m_cnt[i][r] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input bit g, input bit e, input bit l, input bit clr, input bit ack);
        int n, r;
        n = int'(g) + int'(e) + int'(l);
        r = g ? 3 : e ? 2 : 1;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                m_st[i] = 0; m_rrel[i] = 0; m_rlen[i] = 0; m_pulse[i] = 0; m_irq[i] = 0; m_err[i] = 0;
                for (int k = 0; k < 4; k++) m_cnt[i][k] = 0;
                continue;
            end
            m_pulse[i] = 0;
            if (v && n != 1) begin
                if (m_err[i] < cmax[i]) m_err[i]++;
                m_rrel[i] = 0;
                m_rlen[i] = 0;
            end else if (v) begin
                if (r == m_rrel[i]) m_rlen[i] = (m_rlen[i] + 1 > filt[i]) ? filt[i] : m_rlen[i] + 1;
                else begin m_rrel[i] = r; m_rlen[i] = 1; end
                if (m_rlen[i] == filt[i] && r != m_st[i]) begin
                    m_st[i] = r;
                    m_pulse[i] = 1;
                    if (m_cnt[i][r] < cmax[i]) m_cnt[i][r]++;
                end
            end
            if (m_pulse[i] == 1) m_irq[i] = 1;
            else if (ack) m_irq[i] = 0;
        end
    endtask

    task automatic check_all();
        chk("u0.rel_state", 32'(rs0), m_st[0]);
        chk("u0.rel_valid", 32'(rv0), m_st[0] != 0);
        chk("u0.change_pulse", 32'(cp0), m_pulse[0]);
        chk("u0.gt_cnt", 32'(gc0), m_cnt[0][3]);
        chk("u0.eq_cnt", 32'(ec0), m_cnt[0][2]);
        chk("u0.lt_cnt", 32'(lc0), m_cnt[0][1]);
        chk("u0.err_cnt", 32'(er0), m_err[0]);
        chk("u0.irq", 32'(irq0), m_irq[0]);
        chk("u1.rel_state", 32'(rs1), m_st[1]);
        chk("u1.rel_valid", 32'(rv1), m_st[1] != 0);
        chk("u1.change_pulse", 32'(cp1), m_pulse[1]);
        chk("u1.gt_cnt", 32'(gc1), m_cnt[1][3]);
        chk("u1.eq_cnt", 32'(ec1), m_cnt[1][2]);
        chk("u1.lt_cnt", 32'(lc1), m_cnt[1][1]);
        chk("u1.err_cnt", 32'(er1), m_err[1]);
        chk("u1.irq", 32'(irq1), m_irq[1]);
    endtask

    task automatic step(input bit v, input bit g, input bit e, input bit l, input bit clr = 0, input bit ack = 0);
        in_valid = v; a_gt_b = g; a_eq_b = e; a_lt_b = l; clear = clr; irq_ack = ack;
        @(posedge clk);
        #1;
        model_edge(v, g, e, l, clr, ack);
        check_all();
        if (cp1) pulses1++;
        in_valid = 0; clear = 0; irq_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic gt(input bit ack = 0); step(1, 1, 0, 0, 0, ack); endtask
    task automatic eq(input bit ack = 0); step(1, 0, 1, 0, 0, ack); endtask
    task automatic lt(input bit ack = 0); step(1, 0, 0, 1, 0, ack); endtask

    initial begin
        int cur, sel;
        bit f0, f1, f2;
        #1;
        do_reset();
        // GT run qualifies on the third sample; a fourth adds nothing
        gt(); gt(); gt();
        chk("p1_state", 32'(rs0), 3); chk("p1_pulse", 32'(cp0), 1);
        chk("p1_gt", 32'(gc0), 1);    chk("p1_irq", 32'(irq0), 1);
        gt();
        chk("p1_pulse4", 32'(cp0), 0); chk("p1_gt4", 32'(gc0), 1);

        do_reset();
        gt(); gt(); lt(); lt();
        chk("p2_state4", 32'(rs0), 0);
        lt();
        chk("p2_state5", 32'(rs0), 1); chk("p2_lt", 32'(lc0), 1); chk("p2_gt", 32'(gc0), 0);

        do_reset();
        gt(); gt(); step(1, 1, 0, 1); gt();
        chk("p3_state", 32'(rs0), 0); chk("p3_err", 32'(er0), 1);
        gt(); gt();
        chk("p3_state2", 32'(rs0), 3);
        step(1, 0, 0, 0);
        chk("p3_err2", 32'(er0), 2);

        do_reset();
        gt();
        repeat (5) step(0, 0, 0, 0);
        gt(); gt();
        chk("p4_state", 32'(rs0), 3);
        step(0, 0, 0, 0, 0, 1);
        chk("p4_irq", 32'(irq0), 0);
        step(0, 0, 0, 0, 0, 1);
        chk("p4_ack_idle", 32'(irq0), 0);

        step(0, 0, 0, 0, 1);
        pulses1 = 0;
        for (int i = 0; i < 10; i++) if (i % 2 == 0) gt(); else lt();
        chk("p5_pulses", pulses1, 10);
        chk("p5_gt_sat", 32'(gc1), 3); chk("p5_lt_sat", 32'(lc1), 3);

        step(0, 0, 0, 0, 1);
        gt(); gt(); gt();
        chk("p6_irq", 32'(irq0), 1);
        eq(); eq(); eq(1);
        chk("p6_irq_set_wins", 32'(irq0), 1); chk("p6_eq", 32'(ec0), 1);
        step(1, 1, 0, 0, 1);
        chk("p6_clr_state", 32'(rs0), 0); chk("p6_clr_irq", 32'(irq0), 0);
        chk("p6_clr_gt", 32'(gc0), 0);
        gt(); gt();
        chk("p6_run2", 32'(rs0), 0);
        gt();
        chk("p6_run3", 32'(rs0), 3);

        // reset in the middle of a run discards its progress
        do_reset();
        gt(); gt();
        do_reset();
        gt();
        chk("mid_rst_state", 32'(rs0), 0); chk("mid_rst_pulse", 32'(cp0), 0);

        cur = 3;
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 2) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 2) == 0) cur = $urandom_range(1, 3);
            if ($urandom_range(0, 9) == 0) begin
                f0 = 1'($urandom); f1 = 1'($urandom); f2 = 1'($urandom);
            end else begin
                f0 = cur == 3; f1 = cur == 2; f2 = cur == 1;
            end
            step($urandom_range(0, 3) != 0, f0, f1, f2, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/compare_result_monitor.md
Name: compare_result_monitor

Overview:
Downstream consumer of the 4-bit magnitude comparator's one-hot result flags (greater / equal / less).
- Qualifies each sampled result: rejects illegal flag combinations and requires FILT_LEN consecutive identical results before accepting a relation.
- Tracks the accepted relation in a 4-state FSM and counts relation changes per relation.
- Raises a sticky interrupt on each accepted change, cleared by an acknowledge handshake.

Parameters:
FILT_LEN, 3, consecutive identical legal samples required to accept a relation (legal range 1..15).
CNT_W, 8, width of each event counter; counters saturate at 2^CNT_W-1.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  sample strobe for the three flags.
a_gt_b  input  1  comparator "A greater than B" flag.
a_eq_b  input  1  comparator "A equal to B" flag.
a_lt_b  input  1  comparator "A less than B" flag.
clear  input  1  synchronous soft clear.
irq_ack  input  1  interrupt acknowledge.
rel_state  output  2  accepted relation: 00 UNKNOWN, 01 LT, 10 EQ, 11 GT.
rel_valid  output  1  high when rel_state != UNKNOWN.
change_pulse  output  1  one-cycle pulse on each accepted relation change.
gt_cnt  output  CNT_W  number of accepted transitions into GT.
eq_cnt  output  CNT_W  number of accepted transitions into EQ.
lt_cnt  output  CNT_W  number of accepted transitions into LT.
err_cnt  output  CNT_W  number of illegal samples.
irq  output  1  sticky change interrupt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 (rel_state = UNKNOWN).
  - Internal run relation and run length are cleared.
- Sample legality:
  - A sample is taken only on edges with in_valid = 1.
  - Legal means exactly one of a_gt_b, a_eq_b, a_lt_b is 1.
  - Illegal (zero or multiple flags set):
    - err_cnt increments (saturating).
    - run length resets to 0 and the run relation is cleared.
    - rel_state is unchanged.
- Filter, on a legal sample with relation R:
  - If R equals the run relation, run_len <= min(run_len+1, FILT_LEN).
  - Otherwise run relation <= R and run_len <= 1.
  - in_valid low holds everything. Idle gaps do not break a run.
- FSM states UNKNOWN / LT / EQ / GT:
  - Transition on the same edge where the updated run_len equals FILT_LEN and R != rel_state. rel_state <= R on that edge.
  - Latency: the new state is visible immediately after the edge sampling the FILT_LEN-th consecutive identical result.
  - Further identical samples cause no new transition.
  - The FSM never returns to UNKNOWN except via reset or clear.
  - FILT_LEN = 1: every legal sample whose relation differs from rel_state transitions immediately.
- On each accepted transition:
  - change_pulse = 1 for exactly one cycle.
  - The counter of the destination relation increments, saturating at all-ones.
- irq:
  - Set on the same edge as change_pulse.
  - Held until an edge with irq_ack = 1.
  - A new change and irq_ack on the same edge: set wins, irq stays 1.
  - irq_ack while irq = 0 has no effect.
- clear (synchronous):
  - Zeroes all counters, err_cnt, irq, change_pulse, the run state, and sets rel_state to UNKNOWN.
  - Has priority over in_valid and irq_ack on the same edge; that edge's sample is discarded.
- Reset asserted mid-run: all filter progress is discarded. No pulse or irq after release until a fresh qualified run completes.
- All counters are unsigned CNT_W-bit values and never wrap.

Test Plan:
1. FILT_LEN=3; reset, then GT,GT,GT on consecutive valid edges -> rel_state=11 after the 3rd edge, change_pulse high for 1 cycle, gt_cnt=1, irq=1. A 4th GT gives no pulse and gt_cnt stays 1.
2. GT,GT,LT,LT,LT -> rel_state stays 00 through the 4th sample, becomes 01 after the 5th; lt_cnt=1, gt_cnt=0.
3. GT,GT, then illegal (a_gt_b=a_lt_b=1), then GT -> rel_state stays 00, err_cnt=1. Two more GT -> rel_state=11. All-zero flags with in_valid=1 -> err_cnt=2.
4. GT, 5 idle cycles (in_valid=0), GT, GT -> rel_state=11 after the 3rd valid GT. Then irq_ack -> irq=0 next cycle.
5. CNT_W=2, FILT_LEN=1; alternate GT/LT for 10 valid samples -> gt_cnt=3, lt_cnt=3 (saturated), 10 change pulses total.
6. With irq=1, a qualifying EQ change and irq_ack on the same edge -> irq stays 1, eq_cnt=1. Next cycle, clear together with a valid GT sample -> all outputs 0 and the GT sample ignored (the next GT starts run_len at 1).
